// File: rtl/des_key_schedule_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : des_key_schedule_pkg
// Brief   : Shared DES constants: PC-1/PC-2 tables, rotation tables, FSM states
// Revision: 1.0 - initial release
// ============================================================================
package des_key_schedule_pkg;

    localparam int DES_ROUNDS = 16;
    localparam logic [3:0] LAST_ROUND = 4'(DES_ROUNDS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Table entries use DES bit numbering (bit 1 = MSB).
    localparam int PC1_TABLE [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TABLE [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Decrypt entry 0 is zero: PC-1 output already equals C16D16.
    localparam logic [1:0] ROT_ENC [DES_ROUNDS] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    localparam logic [1:0] ROT_DEC [DES_ROUNDS] = '{
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [28:1] rotl28(input logic [28:1] x, input logic [1:0] amt);
        logic [28:1] r;
        case (amt)
            2'd1:    r = {x[27:1], x[28]};
            2'd2:    r = {x[26:1], x[28:27]};
            default: r = x;
        endcase
        return r;
    endfunction

    function automatic logic [28:1] rotr28(input logic [28:1] x, input logic [1:0] amt);
        logic [28:1] r;
        case (amt)
            2'd1:    r = {x[1], x[28:2]};
            2'd2:    r = {x[2:1], x[28:3]};
            default: r = x;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/des_key_schedule_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : des_key_schedule_if
// Brief   : Key-load and subkey-stream signals; parity_err only with
//           DES_KEY_PARITY_CHK_EN defined
// Revision: 1.0 - initial release
// ============================================================================
interface des_key_schedule_if;

    logic [64:1] key;
    logic        decrypt;
    logic        start;
    logic        ready;
    logic [48:1] subk;
    logic        subk_valid;
    logic        subk_ready;
    logic [4:1]  round;
    logic        done;
`ifdef DES_KEY_PARITY_CHK_EN
    logic        parity_err;

    modport master (
        output key, decrypt, start, subk_ready,
        input  ready, subk, subk_valid, round, done, parity_err
    );

    modport slave (
        input  key, decrypt, start, subk_ready,
        output ready, subk, subk_valid, round, done, parity_err
    );
`else
    modport master (
        output key, decrypt, start, subk_ready,
        input  ready, subk, subk_valid, round, done
    );

    modport slave (
        input  key, decrypt, start, subk_ready,
        output ready, subk, subk_valid, round, done
    );
`endif

endinterface
`default_nettype wire

// File: rtl/des_pc2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : des_pc2
// Brief   : Combinational DES PC-2 permutation, {C,D} (56b) -> subkey (48b)
// Revision: 1.0 - initial release
// ============================================================================
module des_pc2
    import des_key_schedule_pkg::*;
(
    input  logic [56:1] cd,
    output logic [48:1] subk
);

    for (genvar g = 0; g < 48; g++) begin : g_pc2
        assign subk[48 - g] = cd[57 - PC2_TABLE[g]];
    end

    // DES bits 9,18,22,25,35,38,43,54 are dropped by PC-2.
    logic w_unused_cd;
    assign w_unused_cd = ^{cd[48], cd[39], cd[35], cd[32], cd[22], cd[19], cd[14], cd[3]};

endmodule
`default_nettype wire

// File: rtl/des_key_schedule.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : des_key_schedule
// Brief   : DES round-key generator, one subkey per cycle with back-pressure;
//           optional key parity check with DES_KEY_PARITY_CHK_EN
// Revision: 1.0 - initial release
// ============================================================================
module des_key_schedule
    import des_key_schedule_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    des_key_schedule_if.slave ks
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_ready;
    logic        w_valid;
    logic        w_done;
    logic        w_accept;
    logic        w_xfer;
    logic        w_last;
    logic        w_load;

    logic [28:1] r_c;
    logic [28:1] r_d;
    logic        r_decrypt;
    logic [4:1]  r_round;

    logic [56:1] w_pc1;
    logic        w_dir;
    logic [3:0]  w_idx;
    logic [1:0]  w_amt;
    logic [28:1] w_c_src;
    logic [28:1] w_d_src;
    logic [28:1] w_c_nxt;
    logic [28:1] w_d_nxt;
    logic [48:1] w_subk;

    for (genvar g = 0; g < 56; g++) begin : g_pc1
        assign w_pc1[56 - g] = ks.key[65 - PC1_TABLE[g]];
    end

    assign w_accept = w_ready & ks.start;
    assign w_xfer   = w_valid & ks.subk_ready;
    assign w_last   = (r_round == LAST_ROUND);
    assign w_load   = w_accept | (w_xfer & ~w_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_valid     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (ks.start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_valid = 1'b1;
                if (ks.subk_ready && w_last) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // On accept the fresh PC-1 value takes the round-0 rotation; otherwise
    // the registered halves advance by the amount for the next round.
    always_comb begin
        w_dir   = w_accept ? ks.decrypt : r_decrypt;
        w_idx   = w_accept ? 4'd0 : r_round + 4'd1;
        w_amt   = w_dir ? ROT_DEC[w_idx] : ROT_ENC[w_idx];
        w_c_src = w_accept ? w_pc1[56:29] : r_c;
        w_d_src = w_accept ? w_pc1[28:1]  : r_d;
        w_c_nxt = w_dir ? rotr28(w_c_src, w_amt) : rotl28(w_c_src, w_amt);
        w_d_nxt = w_dir ? rotr28(w_d_src, w_amt) : rotl28(w_d_src, w_amt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c       <= '0;
            r_d       <= '0;
            r_round   <= '0;
            r_decrypt <= 1'b0;
        end else if (w_load) begin
            r_c     <= w_c_nxt;
            r_d     <= w_d_nxt;
            r_round <= w_idx;
            if (w_accept) begin
                r_decrypt <= ks.decrypt;
            end
        end
    end

    des_pc2 u_pc2 (
        .cd   ({r_c, r_d}),
        .subk (w_subk)
    );

    assign ks.ready      = w_ready;
    assign ks.subk_valid = w_valid;
    assign ks.done       = w_done;
    assign ks.round      = r_round;
    assign ks.subk       = w_subk;

`ifdef DES_KEY_PARITY_CHK_EN
    logic [7:0] w_byte_bad;
    logic       r_parity_err;

    // DES keys use odd parity per byte.
    for (genvar b = 0; b < 8; b++) begin : g_parity
        assign w_byte_bad[b] = ~(^ks.key[8*b+8 -: 8]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity_err <= 1'b0;
        end else if (w_accept) begin
            r_parity_err <= |w_byte_bad;
        end
    end

    assign ks.parity_err = r_parity_err;
`else
    logic w_unused_parity;
    assign w_unused_parity = ^{ks.key[64], ks.key[56], ks.key[48], ks.key[40],
                               ks.key[32], ks.key[24], ks.key[16], ks.key[8]};
`endif

endmodule
`default_nettype wire
